// File: rtl/bank_swap_pkg.sv
// Shared types and defaults for the bank_swap_ctrl ping-pong ADC capture block.
// Optional frame counter is compiled in by defining BANK_SWAP_FRAME_CNT_EN.
package bank_swap_pkg;

   localparam int unsigned ADDR_W_DEF  = 13;
   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned STATE_W     = 2;
   localparam int unsigned FRAME_CNT_W = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_STALL = 2'd2
   } state_e;

endpackage

// File: rtl/bank_swap_addr_cnt.sv
// Write-address counter and bank ownership/swap bookkeeping for bank_swap_ctrl.
// BANK_SWAP_FRAME_CNT_EN adds a wrapping count of completed swaps.
module bank_swap_addr_cnt
   import bank_swap_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              incr,
   input  logic              swap,
   input  logic              ack,
   output logic [ADDR_W-1:0] addr,
   output logic              last_c,
   output logic              wr_bank,
   output logic              rd_bank,
   output logic              sample_rdy
`ifdef BANK_SWAP_FRAME_CNT_EN
   ,
   output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

   assign last_c = (addr == {ADDR_W{1'b1}});

   // Address wraps naturally modulo the bank size.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (clear || swap) begin
         addr <= '0;
      end else if (incr) begin
         addr <= addr + ADDR_W'(1);
      end
   end

   // A swap re-asserts ready even if an ack clears it in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b1;
         sample_rdy <= 1'b0;
      end else if (swap) begin
         rd_bank    <= wr_bank;
         wr_bank    <= ~wr_bank;
         sample_rdy <= 1'b1;
      end else if (ack) begin
         sample_rdy <= 1'b0;
      end
   end

`ifdef BANK_SWAP_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (swap) begin
         frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
   end
`endif

endmodule

// File: rtl/bank_swap_ctrl.sv
// Ping-pong ADC capture controller: fills one RAM bank while the host reads the other.
// Define BANK_SWAP_FRAME_CNT_EN to expose the O_frameCnt swap counter.
module bank_swap_ctrl
   import bank_swap_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic               I_clk,
   input  logic               I_rst_n,
   input  logic               I_start,
   input  logic               I_stop,
   input  logic               I_continuous,
   input  logic               ADC_I_dataValid,
   input  logic [DATA_W-1:0]  ADC_I_data,
   input  logic               I_bankAck,
   output logic               O_wrEn,
   output logic [ADDR_W-1:0]  O_wrAddr,
   output logic [DATA_W-1:0]  O_wrData,
   output logic               O_wrBank,
   output logic               O_rdBank,
   output logic               O_sampleRdy,
   output logic               O_overrun,
   output logic               O_busy,
   output logic [STATE_W-1:0] O_state
`ifdef BANK_SWAP_FRAME_CNT_EN
   ,
   output logic [FRAME_CNT_W-1:0] O_frameCnt
`endif
);

   state_e            state;
   state_e            state_nxt;
   logic              cont_mode;
   logic [ADDR_W-1:0] addr;
   logic              last_c;
   logic              rdy_held_c;
   logic              start_ok_c;
   logic              accept_c;
   logic              swap_c;
   logic              incr_c;
   logic              ovr_set_c;

   // Host bank still unread after any same-cycle ack has been applied.
   assign rdy_held_c = O_sampleRdy && !I_bankAck;

   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         state  <= ST_IDLE;
         O_busy <= 1'b0;
      end else begin
         state  <= state_nxt;
         O_busy <= (state_nxt != ST_IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      if (I_stop) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (I_start) state_nxt = ST_FILL;
            ST_FILL:  if (ADC_I_dataValid && last_c) begin
                         if (rdy_held_c)     state_nxt = ST_STALL;
                         else if (!cont_mode) state_nxt = ST_IDLE;
                      end
            ST_STALL: if (I_bankAck) state_nxt = cont_mode ? ST_FILL : ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      start_ok_c = 1'b0;
      accept_c   = 1'b0;
      swap_c     = 1'b0;
      incr_c     = 1'b0;
      ovr_set_c  = 1'b0;
      if (!I_stop) begin
         case (state)
            ST_IDLE:  start_ok_c = I_start;
            ST_FILL:  begin
                         accept_c = ADC_I_dataValid;
                         swap_c   = ADC_I_dataValid && last_c && !rdy_held_c;
                         incr_c   = ADC_I_dataValid && !(last_c && rdy_held_c);
                      end
            ST_STALL: begin
                         swap_c    = I_bankAck;
                         ovr_set_c = ADC_I_dataValid;
                      end
            default:  ;
         endcase
      end
   end

   // Write port is one cycle behind the accepted sample.
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         O_wrEn    <= 1'b0;
         O_wrAddr  <= '0;
         O_wrData  <= '0;
         O_overrun <= 1'b0;
         cont_mode <= 1'b0;
      end else begin
         O_wrEn <= accept_c;
         if (accept_c) begin
            O_wrAddr <= addr;
            O_wrData <= ADC_I_data;
         end
         if (start_ok_c) begin
            cont_mode <= I_continuous;
            O_overrun <= 1'b0;
         end else if (ovr_set_c) begin
            O_overrun <= 1'b1;
         end
      end
   end

   assign O_state = STATE_W'(state);

   bank_swap_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
      .clk        (I_clk),
      .rst_n      (I_rst_n),
      .clear      (start_ok_c),
      .incr       (incr_c),
      .swap       (swap_c),
      .ack        (I_bankAck),
      .addr       (addr),
      .last_c     (last_c),
      .wr_bank    (O_wrBank),
      .rd_bank    (O_rdBank),
      .sample_rdy (O_sampleRdy)
`ifdef BANK_SWAP_FRAME_CNT_EN
      ,
      .frame_cnt  (O_frameCnt)
`endif
   );

endmodule

// File: tb/tb_bank_swap_ctrl.sv
// Self-checking bench for bank_swap_ctrl: directed scenarios then random traffic vs a rule-level model.
module tb_bank_swap_ctrl;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 16;
   localparam int DEPTH = 1 << ADDR_W;
   localparam int S_IDLE = 0, S_FILL = 1, S_STALL = 2;

   logic              clk;
   logic              rst_n, start, stop, cont, valid, ack;
   logic [DATA_W-1:0] data;
   logic              wr_en, wr_bank, rd_bank, sample_rdy, overrun, busy;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        state;
`ifdef BANK_SWAP_FRAME_CNT_EN
   logic [15:0]       frame_cnt;
`endif

   bank_swap_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .I_clk           (clk),
      .I_rst_n         (rst_n),
      .I_start         (start),
      .I_stop          (stop),
      .I_continuous    (cont),
      .ADC_I_dataValid (valid),
      .ADC_I_data      (data),
      .I_bankAck       (ack),
      .O_wrEn          (wr_en),
      .O_wrAddr        (wr_addr),
      .O_wrData        (wr_data),
      .O_wrBank        (wr_bank),
      .O_rdBank        (rd_bank),
      .O_sampleRdy     (sample_rdy),
      .O_overrun       (overrun),
      .O_busy          (busy),
      .O_state         (state)
`ifdef BANK_SWAP_FRAME_CNT_EN
      ,
      .O_frameCnt      (frame_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model state, expressed as the plain capture rules.
   int m_st = S_IDLE;
   int m_cnt = 0;
   int m_frames = 0;
   bit m_wrbank = 0, m_rdbank = 1, m_rdy = 0, m_ovr = 0, m_cont = 0;
   bit exp_wren = 0;
   int exp_addr = 0;
   int exp_data = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_swap();
      m_rdbank = m_wrbank;
      m_wrbank = !m_wrbank;
      m_rdy    = 1;
      m_cnt    = 0;
      m_frames = (m_frames + 1) % 65536;
      m_st     = m_cont ? S_FILL : S_IDLE;
   endtask

   task automatic model_step();
      exp_wren = 0;
      if (!rst_n) begin
         m_st = S_IDLE; m_cnt = 0; m_frames = 0;
         m_wrbank = 0; m_rdbank = 1; m_rdy = 0; m_ovr = 0; m_cont = 0;
         exp_addr = 0; exp_data = 0;
         return;
      end
      if (stop) begin
         if (ack) m_rdy = 0;
         m_st = S_IDLE;
         return;
      end
      case (m_st)
         S_IDLE: begin
            if (ack) m_rdy = 0;
            if (start) begin
               m_st = S_FILL; m_cnt = 0; m_cont = cont; m_ovr = 0;
            end
         end
         S_FILL: begin
            if (ack) m_rdy = 0;
            if (valid) begin
               exp_wren = 1; exp_addr = m_cnt; exp_data = int'(data);
               if (m_cnt == DEPTH - 1) begin
                  if (!m_rdy) do_swap();
                  else m_st = S_STALL;
               end else begin
                  m_cnt++;
               end
            end
         end
         default: begin
            if (valid) m_ovr = 1;
            if (ack) begin
               m_rdy = 0;
               do_swap();
            end
         end
      endcase
   endtask

   task automatic check_all();
      chk("wr_en",      32'(wr_en),      32'(exp_wren));
      chk("wr_addr",    32'(wr_addr),    32'(exp_addr));
      chk("wr_data",    32'(wr_data),    32'(exp_data));
      chk("wr_bank",    32'(wr_bank),    32'(m_wrbank));
      chk("rd_bank",    32'(rd_bank),    32'(m_rdbank));
      chk("sample_rdy", 32'(sample_rdy), 32'(m_rdy));
      chk("overrun",    32'(overrun),    32'(m_ovr));
      chk("busy",       32'(busy),       32'(m_st != S_IDLE));
      chk("state",      32'(state),      32'(m_st));
`ifdef BANK_SWAP_FRAME_CNT_EN
      chk("frame_cnt",  32'(frame_cnt),  32'(m_frames));
`endif
   endtask

   task automatic cycle(input bit r, input bit st, input bit sp, input bit ct,
                        input bit v, input bit ak);
      rst_n = r; start = st; stop = sp; cont = ct; valid = v; ack = ak;
      data  = DATA_W'($urandom);
      @(posedge clk);
      model_step();
      #1 check_all();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 0; start = 0; stop = 0; cont = 0; valid = 0; ack = 0; data = '0;
      @(negedge clk);
      repeat (2) cycle(0, 0, 0, 0, 0, 0);
      chk("rst_rd_bank", 32'(rd_bank), 32'd1);

      // Continuous fill of the first bank.
      cycle(1, 1, 0, 1, 0, 0);
      repeat (DEPTH) cycle(1, 0, 0, 0, 1, 0);
      chk("fill1_rdy",     32'(sample_rdy), 32'd1);
      chk("fill1_rd_bank", 32'(rd_bank),    32'd0);
      chk("fill1_wr_bank", 32'(wr_bank),    32'd1);
      chk("fill1_last",    32'(wr_addr),    32'(DEPTH - 1));

      // Unacknowledged second bank plus extra samples overruns.
      repeat (DEPTH + 3) cycle(1, 0, 0, 0, 1, 0);
      chk("stall_state", 32'(state),   32'(S_STALL));
      chk("stall_ovr",   32'(overrun), 32'd1);
      chk("stall_wren",  32'(wr_en),   32'd0);
      cycle(1, 0, 0, 0, 0, 1);
      chk("ack_rd_bank", 32'(rd_bank), 32'd1);
      chk("ack_state",   32'(state),   32'(S_FILL));
      cycle(1, 0, 0, 0, 1, 0);
      chk("ack_addr0",   32'(wr_addr), 32'd0);

      // Fresh start, ack coincident with the last sample.
      cycle(1, 0, 1, 0, 0, 0);
      cycle(1, 1, 0, 1, 0, 0);
      repeat (DEPTH - 1) cycle(1, 0, 0, 0, 1, 0);
      cycle(1, 0, 0, 0, 1, 1);
      chk("coinc_rdy",   32'(sample_rdy), 32'd1);
      chk("coinc_ovr",   32'(overrun),    32'd0);
      chk("coinc_state", 32'(state),      32'(S_FILL));

      // Single-shot capture returns to idle and ignores further samples.
      cycle(1, 0, 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 1);
      cycle(1, 1, 0, 0, 0, 0);
      repeat (DEPTH) cycle(1, 0, 0, 0, 1, 0);
      chk("single_busy", 32'(busy), 32'd0);
      repeat (4) cycle(1, 0, 0, 0, 1, 0);
      chk("single_nowr", 32'(wr_en), 32'd0);

      // Stop wins over start mid-bank.
      cycle(1, 1, 0, 1, 0, 0);
      repeat (5) cycle(1, 0, 0, 0, 1, 0);
      cycle(1, 1, 1, 1, 1, 0);
      chk("stopstart_state", 32'(state), 32'(S_IDLE));

      // Reset mid-fill.
      cycle(1, 1, 0, 1, 0, 0);
      repeat (3) cycle(1, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);
      chk("rst_mid_wren", 32'(wr_en),      32'd0);
      chk("rst_mid_rdy",  32'(sample_rdy), 32'd0);
      cycle(1, 0, 0, 0, 1, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 999) > 2,
               $urandom_range(0, 99) < 4,
               $urandom_range(0, 199) < 2,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) < 7,
               $urandom_range(0, 99) < 6);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
